ps2_key_decoder: RTL and testbench

PS/2 keyboard front end for the Tetris game: receives scan-code frames from the PS2_clk/PS2_data pins, validates them, and tracks make/break sequences. Translates the game keys into the 3-bit key code consumed by the top-level `pressed[]` latch logic. Sits directly upstream of the game controller and replaces the unclocked keyboard path with a fully synchronous one.

---
 rtl/ps2_key_decoder_pkg.sv | 54 +++++
 rtl/ps2_key_decoder_if.sv | 11 +
 rtl/ps2_key_decoder_rx.sv | 110 +++++++++++
 rtl/ps2_key_decoder.sv | 72 +++++++
 tb/tb_ps2_key_decoder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared key codes, scan codes, receiver state type and the scan-code to game-key map.
package ps2_key_decoder_pkg;

   localparam logic [2:0] KEY_NONE    = 3'd0;
   localparam logic [2:0] KEY_ESC     = 3'd1;
   localparam logic [2:0] KEY_SPACE   = 3'd2;
   localparam logic [2:0] KEY_ROT_CW  = 3'd3;
   localparam logic [2:0] KEY_ROT_CCW = 3'd4;
   localparam logic [2:0] KEY_LEFT    = 3'd5;
   localparam logic [2:0] KEY_RIGHT   = 3'd6;
   localparam logic [2:0] KEY_DOWN    = 3'd7;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_X     = 8'h22;
   localparam logic [7:0] SC_Z     = 8'h1A;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_DOWN  = 8'h72;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   function automatic logic [2:0] map_scan(input logic ext, input logic [7:0] code);
      logic [2:0] k;
      k = KEY_NONE;
      if (!ext) begin
         case (code)
            SC_ESC:   k = KEY_ESC;
            SC_SPACE: k = KEY_SPACE;
            SC_X:     k = KEY_ROT_CW;
            SC_Z:     k = KEY_ROT_CCW;
            default:  k = KEY_NONE;
         endcase
      end else begin
         case (code)
            SC_UP:    k = KEY_ROT_CW;
            SC_LEFT:  k = KEY_LEFT;
            SC_RIGHT: k = KEY_RIGHT;
            SC_DOWN:  k = KEY_DOWN;
            default:  k = KEY_NONE;
         endcase
      end
      return k;
   endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pins plus the decoded key outputs; master is the decoder, slave the pin/consumer side.
interface ps2_key_decoder_if;
   logic       PS2_clk;
   logic       PS2_data;
   logic [2:0] key;
   logic       key_pulse;
   logic       frame_err;

   modport master (input PS2_clk, PS2_data, output key, key_pulse, frame_err);
   modport slave  (output PS2_clk, PS2_data, input key, key_pulse, frame_err);
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, frame FSM and inactivity watchdog.
//   state     | meaning
//   RX_IDLE   | waiting for a start bit (data 0 on a fall)
//   RX_DATA   | shifting 8 data bits, LSB first
//   RX_PARITY | capturing the parity bit
//   RX_STOP   | checking stop bit and odd parity, then emit byte or error
module ps2_key_decoder_rx
   import ps2_key_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_pin,
   input  logic       ps2_data_pin,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

   logic clk_s1, clk_s2, clk_prev, data_s1, data_s2;
   logic fall;
   rx_state_t state, state_n;
   logic [2:0] cnt, cnt_n;
   logic [7:0] shreg, shreg_n, rx_byte_n;
   logic par, par_n, byte_valid_n, frame_err_n;
   logic [WDW-1:0] wdog, wdog_n;

   assign fall = clk_prev & ~clk_s2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_s1     <= 1'b1;
         clk_s2     <= 1'b1;
         clk_prev   <= 1'b1;
         data_s1    <= 1'b1;
         data_s2    <= 1'b1;
         state      <= RX_IDLE;
         cnt        <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         wdog       <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         clk_s1     <= ps2_clk_pin;
         clk_s2     <= clk_s1;
         clk_prev   <= clk_s2;
         data_s1    <= ps2_data_pin;
         data_s2    <= data_s1;
         state      <= state_n;
         cnt        <= cnt_n;
         shreg      <= shreg_n;
         par        <= par_n;
         wdog       <= wdog_n;
         rx_byte    <= rx_byte_n;
         byte_valid <= byte_valid_n;
         frame_err  <= frame_err_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      shreg_n      = shreg;
      par_n        = par;
      rx_byte_n    = rx_byte;
      byte_valid_n = 1'b0;
      frame_err_n  = 1'b0;
      wdog_n       = (wdog == WD_LAST) ? wdog : wdog + WDW'(1);
      if (fall) begin
         wdog_n = '0;
         case (state)
            RX_IDLE: begin
               if (!data_s2) begin
                  state_n = RX_DATA;
                  cnt_n   = '0;
               end
            end
            RX_DATA: begin
               shreg_n = {data_s2, shreg[7:1]};
               cnt_n   = cnt + 3'd1;
               if (cnt == 3'd7) state_n = RX_PARITY;
            end
            RX_PARITY: begin
               par_n   = data_s2;
               state_n = RX_STOP;
            end
            RX_STOP: begin
               state_n = RX_IDLE;
               if (data_s2 && (^{shreg, par})) begin
                  byte_valid_n = 1'b1;
                  rx_byte_n    = shreg;
               end else begin
                  frame_err_n = 1'b1;
               end
            end
            default: state_n = RX_IDLE;
         endcase
      end else if (state != RX_IDLE && wdog == WD_LAST) begin
         // Stalled partial frame: drop it silently.
         state_n = RX_IDLE;
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder top: make/break tracking and held-key register.
// Build option PS2_REPEAT_EN: a typematic repeat of the held key re-asserts key_pulse.
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input logic                clk,
   input logic                rst,
   ps2_key_decoder_if.master  bus
);

   logic [7:0] rx_byte;
   logic       byte_valid, rx_err;
   logic       ext, brk;
   logic [2:0] key_q, m;
   logic       key_pulse_q, frame_err_q;

   ps2_key_decoder_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk          (clk),
      .rst          (rst),
      .ps2_clk_pin  (bus.PS2_clk),
      .ps2_data_pin (bus.PS2_data),
      .rx_byte      (rx_byte),
      .byte_valid   (byte_valid),
      .frame_err    (rx_err)
   );

   assign m             = map_scan(ext, rx_byte);
   assign bus.key       = key_q;
   assign bus.key_pulse = key_pulse_q;
   assign bus.frame_err = frame_err_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ext         <= 1'b0;
         brk         <= 1'b0;
         key_q       <= KEY_NONE;
         key_pulse_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         key_pulse_q <= 1'b0;
         frame_err_q <= rx_err;
         if (rx_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byte_valid) begin
            if (rx_byte == SC_EXT) begin
               ext <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
               brk <= 1'b1;
            end else begin
               ext <= 1'b0;
               brk <= 1'b0;
               if (m != KEY_NONE) begin
                  if (brk) begin
                     if (m == key_q) key_q <= KEY_NONE;
                  end else begin
                     if (m != key_q) key_q <= m;
`ifdef PS2_REPEAT_EN
                     key_pulse_q <= 1'b1;
`else
                     key_pulse_q <= (m != key_q);
`endif
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios then random key traffic vs. a reference model.
module tb_ps2_key_decoder;

   localparam int TO   = 300;
   localparam int HALF = 8;
`ifdef PS2_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ps2_key_decoder_if bus();
   ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pulse_cnt = 0, pulse_at = -1, err_cnt = 0, err_at = -1, stop_cyc = 0;
   always @(negedge clk) begin
      if (bus.key_pulse === 1'b1) begin pulse_cnt++; pulse_at = cyc; end
      if (bus.frame_err === 1'b1) begin err_cnt++; err_at = cyc; end
   end

   int passed = 0, total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Reference model: game key table and held-key/prefix state.
   int tbl_code[8] = '{'h76, 'h29, 'h22, 'h1A, 'h75, 'h6B, 'h74, 'h72};
   bit tbl_ext[8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
   int tbl_key[8]  = '{1, 2, 3, 4, 3, 5, 6, 7};
   bit m_ext = 0, m_brk = 0;
   int m_key = 0;

   function automatic int ref_map(bit e, int c);
      for (int i = 0; i < 8; i++)
         if (tbl_code[i] == c && tbl_ext[i] == e) return tbl_key[i];
      return 0;
   endfunction

   function automatic logic [10:0] build(logic [7:0] b, bit bad_par, bit bad_stop);
      logic p;
      p = ~(^b) ^ bad_par;
      return {~bad_stop, p, b, 1'b0};
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [10:0] bits, input int from, input int upto);
      for (int i = from; i <= upto; i++) begin
         bus.PS2_data = bits[i];
         wait_cyc(HALF);
         bus.PS2_clk = 1'b0;
         stop_cyc = cyc;
         wait_cyc(HALF);
         bus.PS2_clk = 1'b1;
      end
      bus.PS2_data = 1'b1;
      wait_cyc(HALF);
   endtask

   task automatic clear_mon();
      pulse_cnt = 0; pulse_at = -1; err_cnt = 0; err_at = -1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input string tag);
      int k;
      bit exp_pulse, exp_err;
      exp_pulse = 0;
      exp_err   = bad_par | bad_stop;
      if (exp_err) begin
         m_ext = 0; m_brk = 0;
      end else if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         k = ref_map(m_ext, int'(b));
         if (k != 0) begin
            if (m_brk) begin
               if (k == m_key) m_key = 0;
            end else begin
               exp_pulse = (k != m_key) || REP;
               m_key = k;
            end
         end
         m_ext = 0; m_brk = 0;
      end
      clear_mon();
      send_bits(build(b, bad_par, bad_stop), 0, 10);
      chk({tag, " key"}, 32'(bus.key), m_key);
      chk({tag, " pulses"}, pulse_cnt, 32'(exp_pulse));
      chk({tag, " errs"}, err_cnt, 32'(exp_err));
      if (exp_pulse) chk({tag, " pulse latency"}, pulse_at - stop_cyc, 4);
      if (exp_err) chk({tag, " err latency"}, err_at - stop_cyc, 4);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r, idx, pc;
      logic [7:0] b;
      bus.PS2_clk  = 1'b1;
      bus.PS2_data = 1'b1;
      rst = 1'b0;
      wait_cyc(3);
      chk("reset key", 32'(bus.key), 0);
      chk("reset key_pulse", 32'(bus.key_pulse), 0);
      chk("reset frame_err", 32'(bus.frame_err), 0);
      rst = 1'b1;
      wait_cyc(2);

      send_frame(8'hE0, 0, 0, "left ext");
      send_frame(8'h6B, 0, 0, "left make");
      send_frame(8'hE0, 0, 0, "left brk ext");
      send_frame(8'hF0, 0, 0, "left brk f0");
      send_frame(8'h6B, 0, 0, "left break");

      send_frame(8'h22, 1, 0, "x bad parity");
      send_frame(8'h22, 0, 0, "x make");

      send_frame(8'h1A, 0, 0, "z make");
      send_frame(8'h1A, 0, 0, "z repeat");

      send_frame(8'h29, 0, 0, "space make");
      send_frame(8'hE0, 0, 0, "down ext");
      send_frame(8'h72, 0, 0, "down make");
      send_frame(8'hF0, 0, 0, "space brk f0");
      send_frame(8'h29, 0, 0, "space break other");

      // Partial frame abandoned by the watchdog.
      clear_mon();
      send_bits(build(8'h55, 0, 0), 0, 5);
      wait_cyc(TO + 20);
      chk("timeout no err", err_cnt, 0);
      chk("timeout no pulse", pulse_cnt, 0);
      send_frame(8'h76, 0, 0, "esc after timeout");

      send_frame(8'h29, 0, 1, "bad stop");

      // Reset in the middle of a frame while a key is held.
      send_frame(8'hE0, 0, 0, "right ext");
      send_frame(8'h74, 0, 0, "right make");
      clear_mon();
      send_bits(build(8'h29, 0, 0), 0, 3);
      rst = 1'b0;
      wait_cyc(1);
      chk("midreset key", 32'(bus.key), 0);
      chk("midreset key_pulse", 32'(bus.key_pulse), 0);
      chk("midreset frame_err", 32'(bus.frame_err), 0);
      rst = 1'b1;
      m_key = 0; m_ext = 0; m_brk = 0;
      clear_mon();
      send_bits(build(8'h29, 0, 0), 4, 10);
      wait_cyc(TO + 20);
      chk("aborted rest pulses", pulse_cnt, 0);
      chk("aborted rest errs", err_cnt, 0);
      chk("aborted rest key", 32'(bus.key), 0);

      // Random key traffic.
      for (int n = 0; n < 50; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) begin
            b = 8'($urandom_range(0, 255));
            pc = $urandom_range(0, 1);
            send_frame(b, pc == 1, pc == 0, "rnd corrupt");
         end else if (r == 1) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hE0 || b == 8'hF0) b = 8'h00;
            send_frame(b, 0, 0, "rnd other");
         end else begin
            idx = $urandom_range(0, 7);
            if (tbl_ext[idx]) send_frame(8'hE0, 0, 0, "rnd ext");
            if ($urandom_range(0, 2) == 0) send_frame(8'hF0, 0, 0, "rnd f0");
            send_frame(8'(tbl_code[idx]), 0, 0, "rnd code");
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
